// File: rtl/spi_mem_responder.sv
// SPI mode-0 responder fronting a small flop-based memory: oversampled on clk, one command
// byte (R/W + start address) followed by auto-incrementing data bytes.
module spi_mem_responder #(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sclk_i,
    input  logic              cs_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oe_o,
    input  logic              ld_en_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic              done_o,
    output logic              busy_o
);

    localparam int unsigned Depth = 1 << ADDR_W;

    typedef enum logic [1:0] {StIdle, StCmd, StWdata, StRdata} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    state_e                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0]      addr_q, addr_d, addr_inc;
    logic [DATA_W-1:0]      in_q, in_d, out_q, out_d, byte_in;
    logic                   done_q, done_d, busy_q, busy_d;
    logic [DATA_W-1:0]      mem_q [Depth];
    logic                   mem_we;
    logic [ADDR_W-1:0]      mem_waddr;
    logic [DATA_W-1:0]      mem_wdata;
    logic                   last_bit;

    // cs chain resets low so a cs still held low after reset never looks like a new frame
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= SYNC_STAGES'({sclk_sync_q, sclk_i});
            cs_sync_q   <= SYNC_STAGES'({cs_sync_q, cs_i});
            mosi_sync_q <= SYNC_STAGES'({mosi_sync_q, mosi_i});
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;

    assign byte_in  = {in_q[DATA_W-2:0], mosi_s};
    assign addr_inc = addr_q + ADDR_W'(1);
    assign last_bit = sclk_rise && (bit_cnt_q == 3'd7);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        addr_d    = addr_q;
        in_d      = in_q;
        out_d     = out_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wdata = byte_in;

        if (state_q == StIdle && ld_en_i) begin
            mem_we    = 1'b1;
            mem_waddr = ld_addr_i;
            mem_wdata = ld_data_i;
        end

        if (cs_rise) begin
            state_d   = StIdle;
            bit_cnt_d = '0;
            out_d     = '0;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cs_fall) begin
                        state_d   = StCmd;
                        bit_cnt_d = '0;
                        busy_d    = 1'b1;
                    end
                end
                StCmd: begin
                    if (sclk_rise) begin
                        in_d      = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            addr_d = byte_in[ADDR_W-1:0];
                            if (byte_in[7]) begin
                                state_d = StRdata;
                                out_d   = mem_q[byte_in[ADDR_W-1:0]];
                            end else begin
                                state_d = StWdata;
                            end
                        end
                    end
                end
                StWdata: begin
                    if (sclk_rise) begin
                        in_d      = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            mem_we = 1'b1;
                            addr_d = addr_inc;
                            done_d = 1'b1;
                        end
                    end
                end
                StRdata: begin
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            addr_d = addr_inc;
                            out_d  = mem_q[addr_inc];
                            done_d = 1'b1;
                        end
                    // No shift on the falling edge right after a reload: that MSB must stay out.
                    end else if (sclk_fall && bit_cnt_q != 3'd0) begin
                        out_d = {out_q[DATA_W-2:0], 1'b0};
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            addr_q    <= '0;
            in_q      <= '0;
            out_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            addr_q    <= addr_d;
            in_q      <= in_d;
            out_q     <= out_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign miso_o    = (state_q == StRdata) & out_q[DATA_W-1];
    assign miso_oe_o = (state_q == StRdata);
    assign done_o    = done_q;
    assign busy_o    = busy_q;

endmodule
